axi_lite_lsu_master: RTL and testbench

Load/store initiator between the CPU memory stage and the AXI4-Lite interconnect. It turns one CPU load or store into one AXI4-Lite read or write transaction. Stores use byte strobes; loads are aligned and sign- or zero-extended. The CPU is stalled until the bus response completes. This block is the requesting end of the path that terminates in the SoC data memory and peripherals.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/load_align.sv | 38 +++
 rtl/axi_lite_lsu_master.sv | 169 ++++++++++++++++
 tb/tb_axi_lite_lsu_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings, FSM states and store-lane helpers for the
//               AXI4-Lite load/store initiator and the load alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t S_IDLE  = 3'd0;
    localparam lsu_state_t S_WRITE = 3'd1;
    localparam lsu_state_t S_WRESP = 3'd2;
    localparam lsu_state_t S_RADDR = 3'd3;
    localparam lsu_state_t S_RDATA = 3'd4;
    localparam lsu_state_t S_DONE  = 3'd5;

    // Reserved store type yields an all-zero strobe but still goes on the bus
    function automatic logic [3:0] store_strb(input logic [1:0] st, input logic [1:0] off);
        case (st)
            ST_B:    store_strb = 4'b0001 << off;
            ST_H:    store_strb = off[1] ? 4'b1100 : 4'b0011;
            ST_W:    store_strb = 4'b1111;
            default: store_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
        case (st)
            ST_B:    store_data = {4{wd[7:0]}};
            ST_H:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Combinational load aligner: selects byte/half from a bus word
//               and sign- or zero-extends it according to RV32 funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;

    // Halfwords select on offset[1] only, so offset[0] never splits a lane
    assign w_byte_shift = rdata >> {offset, 3'b000};
    assign w_half_shift = rdata >> {offset[1], 4'b0000};

    always_comb begin
        data = w_byte_shift;
        case (load_type)
            LD_B:    data = {{24{w_byte_shift[7]}}, w_byte_shift[7:0]};
            LD_BU:   data = {24'd0, w_byte_shift[7:0]};
            LD_H:    data = {{16{w_half_shift[15]}}, w_half_shift[15:0]};
            LD_HU:   data = {16'd0, w_half_shift[15:0]};
            default: data = w_byte_shift;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_lite_lsu_master.sv
// ============================================================================
// Module      : axi_lite_lsu_master
// Description : CPU load/store to single AXI4-Lite transaction initiator with
//               CPU stall. Optional response error tracking: LSU_RESP_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        store_type,
    input  logic [2:0]        load_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              bus_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    lsu_state_t        r_state;
    logic [ADDR_W-1:0] r_awaddr;
    logic [ADDR_W-1:0] r_araddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_arvalid;
    logic [2:0]        r_load_type;
    logic [1:0]        r_offset;
    logic [31:0]       r_load_data;

    logic [ADDR_W-1:0] w_word_addr;
    logic [31:0]       w_aligned;
    logic [31:0]       w_load_result;
    logic              w_aw_done;
    logic              w_w_done;

    assign w_word_addr = {addr[ADDR_W-1:2], 2'b00};
    // A channel counts as finished if it already handshook or handshakes now
    assign w_aw_done   = !r_awvalid || m_awready;
    assign w_w_done    = !r_wvalid || m_wready;

    load_align u_load_align (
        .rdata     (m_rdata),
        .offset    (r_offset),
        .load_type (r_load_type),
        .data      (w_aligned)
    );

`ifdef LSU_RESP_ERR_EN
    logic r_bus_err;

    assign w_load_result = (m_rresp != RESP_OKAY) ? 32'd0 : w_aligned;
    assign bus_err       = r_bus_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if ((r_state == S_WRESP && m_bvalid && m_bresp != RESP_OKAY) ||
                     (r_state == S_RDATA && m_rvalid && m_rresp != RESP_OKAY)) begin
            r_bus_err <= 1'b1;
        end
    end
`else
    logic w_unused_resp;

    assign w_unused_resp = ^{m_bresp, m_rresp};
    assign w_load_result = w_aligned;
    assign bus_err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_load_type <= 3'd0;
            r_offset    <= 2'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_write) begin
                        r_awaddr  <= w_word_addr;
                        r_wdata   <= store_data(store_type, write_data);
                        r_wstrb   <= store_strb(store_type, addr[1:0]);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WRITE;
                    end else if (mem_read) begin
                        r_araddr    <= w_word_addr;
                        r_arvalid   <= 1'b1;
                        r_load_type <= load_type;
                        r_offset    <= addr[1:0];
                        r_state     <= S_RADDR;
                    end
                end
                S_WRITE: begin
                    if (m_awready) r_awvalid <= 1'b0;
                    if (m_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) r_state <= S_WRESP;
                end
                S_WRESP: begin
                    if (m_bvalid) r_state <= S_DONE;
                end
                S_RADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        r_load_data <= w_load_result;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall     = (r_state == S_IDLE) ? (mem_read || mem_write) : (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign load_data = r_load_data;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = (r_state == S_WRESP);
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = (r_state == S_RDATA);

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_lsu_master.sv
// ============================================================================
// Module      : tb_axi_lite_lsu_master
// Description : Scoreboard bench for axi_lite_lsu_master with a reactive
//               AXI4-Lite slave; honours LSU_RESP_ERR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_lsu_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]  store_type = 2'd0;
    logic [2:0]  load_type = 3'd0;
    logic [31:0] addr = 32'd0, write_data = 32'd0;
    logic        stall, done, bus_err;
    logic [31:0] load_data;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic        m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'd0, m_rresp = 2'd0;
    logic [31:0] m_rdata = 32'd0;

    always #5 clk = ~clk;

    axi_lite_lsu_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .store_type(store_type), .load_type(load_type), .addr(addr), .write_data(write_data),
        .stall(stall), .done(done), .load_data(load_data), .bus_err(bus_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        bit          chk_wdata;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] ld_exp;
        logic        err_exp;
    } txn_t;

    txn_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          rand_delays = 0;
    logic [31:0] model_load = 32'd0;
    logic        model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load: pick the addressed byte/halfword arithmetically, then extend
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int lt);
        int b, h;
        b = int'((rd >> (8 * off)) & 32'hFF);
        h = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
        case (lt)
            0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
            1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return rd >> (8 * off);
        endcase
    endfunction

    task automatic ref_store(input int st, input int off, input logic [31:0] d,
                             output logic [3:0] strb, output logic [31:0] wd);
        case (st)
            0:       begin strb = 4'(1 << off);       wd = (d & 32'hFF) * 32'h01010101; end
            1:       begin strb = 4'(3 << (off & 2)); wd = (d & 32'hFFFF) * 32'h00010001; end
            2:       begin strb = 4'hF;               wd = d; end
            default: begin strb = 4'h0;               wd = d; end
        endcase
    endtask

    task automatic issue(input bit wr, input int ty, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input logic [1:0] resp);
        txn_t t;
        t.is_wr = wr;
        t.addr  = a & 32'hFFFF_FFFC;
        t.rdata = rd;
        t.resp  = resp;
        if (wr) begin
            ref_store(ty, int'(a & 3), d, t.strb, t.wdata);
            t.chk_wdata = (ty != 3);
        end else begin
            t.strb = 4'h0; t.wdata = 32'd0; t.chk_wdata = 0;
`ifdef LSU_RESP_ERR_EN
            model_load = (resp != 2'b00) ? 32'd0 : ref_load(rd, int'(a & 3), ty);
`else
            model_load = ref_load(rd, int'(a & 3), ty);
`endif
        end
`ifdef LSU_RESP_ERR_EN
        if (resp != 2'b00) model_err = 1'b1;
`endif
        t.ld_exp  = model_load;
        t.err_exp = model_err;
        exp_q.push_back(t);
        mem_write  = wr;
        mem_read   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        store_type = 2'(ty);
        load_type  = 3'(ty);
        addr       = a;
        write_data = d;
    endtask

    // Issue at a negedge, then wait (bounded) for done; reports latency and activity counts
    task automatic run_txn(input bit wr, input int ty, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input logic [1:0] resp,
                           output int lat, output int stall_cnt, output int awv_cnt, output int wv_cnt);
        issue(wr, ty, a, d, rd, resp);
        #1;
        stall_cnt = stall ? 1 : 0;
        lat = -1; awv_cnt = 0; wv_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (m_awvalid) awv_cnt++;
            if (m_wvalid) wv_cnt++;
            if (done) begin lat = k; break; end
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done, bus_err, stall}), 32'd0);
        check({tag, "_awaddr"}, m_awaddr, 32'd0);
        check({tag, "_araddr"}, m_araddr, 32'd0);
        check({tag, "_wdata"}, m_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(m_wstrb), 32'd0);
        check({tag, "_load_data"}, load_data, 32'd0);
    endtask

    // Reactive slave plus scoreboard monitor, all evaluated on the falling edge
    bit          aw_got = 0, w_got = 0, ar_got = 0, b_hs = 0, r_hs = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit          prev_done = 0, prev_aw_hs = 0, prev_w_hs = 0, prev_ar_hs = 0;
    logic        prev_awv = 0, prev_wv = 0, prev_arv = 0;
    logic [31:0] prev_awaddr = 0, prev_wdata = 0, prev_araddr = 0;
    logic [3:0]  prev_wstrb = 0;

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                prev_done = 0; prev_aw_hs = 0; prev_w_hs = 0; prev_ar_hs = 0;
                prev_awv = 0; prev_wv = 0; prev_arv = 0;
                continue;
            end
            if (prev_awv && !prev_aw_hs)
                check("aw_hold", 32'(m_awvalid && m_awaddr == prev_awaddr), 32'd1);
            if (prev_wv && !prev_w_hs)
                check("w_hold", 32'(m_wvalid && m_wdata == prev_wdata && m_wstrb == prev_wstrb), 32'd1);
            if (prev_arv && !prev_ar_hs)
                check("ar_hold", 32'(m_arvalid && m_araddr == prev_araddr), 32'd1);

            if (b_hs) m_bvalid = 0;
            if (r_hs) m_rvalid = 0;
            if (m_awready) begin
                m_awready = 0; aw_cnt = 0;
                if (rand_delays) aw_delay = $urandom_range(0, 3);
            end else if (m_awvalid) begin
                aw_cnt++;
                if (aw_cnt > aw_delay) m_awready = 1;
            end
            if (m_wready) begin
                m_wready = 0; w_cnt = 0;
                if (rand_delays) w_delay = $urandom_range(0, 3);
            end else if (m_wvalid) begin
                w_cnt++;
                if (w_cnt > w_delay) m_wready = 1;
            end
            if (m_arready) begin
                m_arready = 0; ar_cnt = 0;
                if (rand_delays) ar_delay = $urandom_range(0, 3);
            end else if (m_arvalid) begin
                ar_cnt++;
                if (ar_cnt > ar_delay) m_arready = 1;
            end
            if (aw_got && w_got && !m_bvalid) begin
                b_cnt++;
                if (b_cnt > b_delay) begin
                    m_bvalid = 1;
                    m_bresp  = (exp_q.size() != 0) ? exp_q[0].resp : 2'b00;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                    if (rand_delays) b_delay = $urandom_range(0, 3);
                end
            end
            if (ar_got && !m_rvalid) begin
                r_cnt++;
                if (r_cnt > r_delay) begin
                    m_rvalid = 1;
                    m_rdata  = (exp_q.size() != 0) ? exp_q[0].rdata : 32'd0;
                    m_rresp  = (exp_q.size() != 0) ? exp_q[0].resp : 2'b00;
                    ar_got = 0; r_cnt = 0;
                    if (rand_delays) r_delay = $urandom_range(0, 3);
                end
            end

            // Handshakes that will be sampled at the coming rising edge
            prev_aw_hs = m_awvalid && m_awready;
            prev_w_hs  = m_wvalid && m_wready;
            prev_ar_hs = m_arvalid && m_arready;
            b_hs       = m_bvalid && m_bready;
            r_hs       = m_rvalid && m_rready;
            if (prev_aw_hs) begin
                aw_got = 1;
                if (exp_q.size() != 0) check("awaddr", m_awaddr, exp_q[0].addr);
            end
            if (prev_w_hs) begin
                w_got = 1;
                if (exp_q.size() != 0) begin
                    check("wstrb", 32'(m_wstrb), 32'(exp_q[0].strb));
                    if (exp_q[0].chk_wdata) check("wdata", m_wdata, exp_q[0].wdata);
                end
            end
            if (prev_ar_hs) begin
                ar_got = 1;
                if (exp_q.size() != 0) begin
                    check("araddr", m_araddr, exp_q[0].addr);
                    check("ar_for_load", 32'(exp_q[0].is_wr), 32'd0);
                end
            end
            if (m_bready) check("bready_after_aw_w", 32'(m_awvalid || m_wvalid), 32'd0);

            if (done) begin
                check("done_single", 32'(prev_done), 32'd0);
                check("stall_in_done", 32'(stall), 32'd0);
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("load_data", load_data, t.ld_exp);
                    check("bus_err", 32'(bus_err), 32'(t.err_exp));
                end
            end
            prev_done   = done;
            prev_awv    = m_awvalid; prev_awaddr = m_awaddr;
            prev_wv     = m_wvalid;  prev_wdata  = m_wdata; prev_wstrb = m_wstrb;
            prev_arv    = m_arvalid; prev_araddr = m_araddr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat, sc, awc, wvc;
        logic [31:0] a, d, rd;
        logic [1:0]  resp;
        int ty;
        bit wr;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(1, 2, 32'h104, 32'hDEADBEEF, 0, 0, lat, sc, awc, wvc);
        check("sw_latency", 32'(lat), 32'd3);
        check("sw_stall_cycles", 32'(sc), 32'd3);
        @(negedge clk);
        run_txn(1, 0, 32'h203, 32'h000000A5, 0, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(1, 1, 32'h102, 32'h00001234, 0, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(1, 3, 32'h10, 32'h55AA55AA, 0, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(0, 0, 32'h300, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        check("lb_latency", 32'(lat), 32'd3);
        @(negedge clk);
        run_txn(0, 0, 32'h302, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(1, 2, 32'h20, 32'h0BADF00D, 0, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(0, 4, 32'h302, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(0, 1, 32'h302, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(0, 5, 32'h300, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(0, 2, 32'h300, 0, 32'h80F07F01, 0, lat, sc, awc, wvc);
        @(negedge clk);

        aw_delay = 3;
        run_txn(1, 2, 32'h500, 32'hCAFEF00D, 0, 0, lat, sc, awc, wvc);
        check("skew_awvalid_cycles", 32'(awc), 32'd4);
        check("skew_wvalid_cycles", 32'(wvc), 32'd1);
        aw_delay = 0;
        @(negedge clk);

        // Abandon a read while the bus is still in its data phase
        r_delay = 6;
        issue(0, 2, 32'h400, 0, 32'h11112222, 0);
        for (int k = 0; k < 20 && !m_rready; k++) @(negedge clk);
        check("reached_rdata", 32'(m_rready), 32'd1);
        #2 rst = 1'b1;
        mem_read = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        model_load = 32'd0;
        model_err  = 1'b0;
        r_delay    = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_txn(0, 2, 32'h404, 0, 32'h33334444, 0, lat, sc, awc, wvc);
        check("lw_after_reset_latency", 32'(lat), 32'd3);
        @(negedge clk);

`ifdef LSU_RESP_ERR_EN
        run_txn(0, 2, 32'h408, 0, 32'h55556666, 2'b10, lat, sc, awc, wvc);
        @(negedge clk);
        run_txn(1, 2, 32'h40C, 32'h12345678, 0, 0, lat, sc, awc, wvc);
        @(negedge clk);
`endif

        rand_delays = 1;
        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = $urandom;
            d    = $urandom;
            rd   = $urandom;
            resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (wr) begin
                ty = $urandom_range(0, 3);
            end else begin
                ty = $urandom_range(0, 7);
                if (ty == 2 || ty == 3 || ty >= 6) a = a & 32'hFFFF_FFFC;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(wr, ty, a, d, rd, resp, lat, sc, awc, wvc);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
